gir_wb_ctrl: RTL and testbench

//  Write-back controller: the writer side of the general integer register file.
//  - Merges ALU results with responses from a single outstanding load.
//  - Registers the chosen result and drives the register file write port (wen / wt_index / wdata).
//  - Keeps a busy scoreboard so the decode stage can detect read-after-write hazards on rs1/rs2.

---
 rtl/gir_wb_ctrl_pkg.sv | 28 ++
 rtl/gir_wb_ctrl_if.sv | 48 ++++
 rtl/gir_scoreboard.sv | 35 +++
 rtl/gir_wb_ctrl.sv | 104 ++++++++++
 tb/tb_gir_wb_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gir_wb_ctrl_pkg.sv
// Shared types and constants for the general integer register write-back controller.
// XLEN normally comes from the global build; 64 is the fallback width.
`ifndef XLEN
`define XLEN 64
`endif

package gir_wb_ctrl_pkg;

  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_IDX_W = $clog2(NREG);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [`XLEN-1:0]     xlen_t;

  typedef enum logic {
    StIdle   = 1'b0,
    StLdWait = 1'b1
  } ld_state_e;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_LSU = 1'b1;

  // x0 is hard-wired: it is never written and never tracked as busy.
  function automatic logic idx_live(input reg_idx_t idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/gir_wb_ctrl_if.sv
// ALU / load / register-file-write / hazard-lookup bundle of the write-back controller.
// Forwarding signals exist only when GIR_WB_BYPASS_EN is defined.
interface gir_wb_ctrl_if
  import gir_wb_ctrl_pkg::*;
();

  logic     alu_valid;
  reg_idx_t alu_rd;
  xlen_t    alu_data;
  logic     alu_ready;
  logic     ld_issue;
  reg_idx_t ld_rd;
  logic     ld_issue_ready;
  logic     ld_resp_valid;
  xlen_t    ld_resp_data;
  logic     ld_resp_ready;
  logic     wen;
  reg_idx_t wt_index;
  xlen_t    wdata;
  reg_idx_t rs1_index;
  reg_idx_t rs2_index;
  logic     rs1_busy;
  logic     rs2_busy;
`ifdef GIR_WB_BYPASS_EN
  logic     rs1_fwd;
  logic     rs2_fwd;
  xlen_t    fwd_data;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_resp_valid, ld_resp_data,
           rs1_index, rs2_index,
`ifdef GIR_WB_BYPASS_EN
    input  rs1_fwd, rs2_fwd, fwd_data,
`endif
    input  alu_ready, ld_issue_ready, ld_resp_ready, wen, wt_index, wdata, rs1_busy, rs2_busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_resp_valid, ld_resp_data,
           rs1_index, rs2_index,
`ifdef GIR_WB_BYPASS_EN
    output rs1_fwd, rs2_fwd, fwd_data,
`endif
    output alu_ready, ld_issue_ready, ld_resp_ready, wen, wt_index, wdata, rs1_busy, rs2_busy
  );

endinterface

// File: rtl/gir_scoreboard.sv
// Busy vector for the integer register file: one set port, one clear port, two lookups.
// A set and a clear of the same index on one edge leave the bit set.
module gir_scoreboard
  import gir_wb_ctrl_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     set_en_i,
  input  reg_idx_t set_idx_i,
  input  logic     clr_en_i,
  input  reg_idx_t clr_idx_i,
  input  reg_idx_t rs1_idx_i,
  input  reg_idx_t rs2_idx_i,
  output logic     rs1_busy_o,
  output logic     rs2_busy_o
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i && idx_live(set_idx_i)) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign rs1_busy_o = busy_q[rs1_idx_i];
  assign rs2_busy_o = busy_q[rs2_idx_i];

endmodule

// File: rtl/gir_wb_ctrl.sv
// Write-back controller: arbitrates ALU results against one outstanding load, registers the
// winner onto the register file write port and reports RAW hazards. Option: GIR_WB_BYPASS_EN.
module gir_wb_ctrl
  import gir_wb_ctrl_pkg::*;
(
  input logic          clk,
  input logic          rst,
  gir_wb_ctrl_if.slave bus
);

  ld_state_e state_q, state_d;
  reg_idx_t  ld_rd_q, ld_rd_d;
  logic      ld_acc, alu_acc, wb_src;
  reg_idx_t  acc_rd;
  xlen_t     acc_data;
  logic      wen_q, wen_d;
  reg_idx_t  wt_index_q, wt_index_d;
  xlen_t     wdata_q, wdata_d;
  logic      sb_rs1_busy, sb_rs2_busy;
  logic      rs1_hit, rs2_hit;

  assign bus.ld_issue_ready = (state_q == StIdle);
  assign bus.ld_resp_ready  = (state_q == StLdWait);
  assign ld_acc             = bus.ld_resp_ready & bus.ld_resp_valid;
  // The load response wins a tie; the ALU result simply waits a cycle.
  assign bus.alu_ready      = ~ld_acc;
  assign alu_acc            = bus.alu_valid & bus.alu_ready;

  always_comb begin
    state_d = state_q;
    ld_rd_d = ld_rd_q;
    unique case (state_q)
      StIdle: begin
        if (bus.ld_issue) begin
          state_d = StLdWait;
          ld_rd_d = bus.ld_rd;
        end
      end
      StLdWait: begin
        if (ld_acc) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wb_src     = ld_acc ? WB_SRC_LSU : WB_SRC_ALU;
    acc_rd     = (wb_src == WB_SRC_LSU) ? ld_rd_q          : bus.alu_rd;
    acc_data   = (wb_src == WB_SRC_LSU) ? bus.ld_resp_data : bus.alu_data;
    // An x0 result completes its handshake but never reaches the register file.
    wen_d      = (ld_acc | alu_acc) & idx_live(acc_rd);
    wt_index_d = wen_d ? acc_rd   : wt_index_q;
    wdata_d    = wen_d ? acc_data : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ld_rd_q    <= '0;
      wen_q      <= 1'b0;
      wt_index_q <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      wen_q      <= wen_d;
      wt_index_q <= wt_index_d;
      wdata_q    <= wdata_d;
    end
  end

  gir_scoreboard u_scoreboard (
    .clk_i      (clk),
    .rst_i      (rst),
    .set_en_i   (bus.ld_issue & bus.ld_issue_ready),
    .set_idx_i  (bus.ld_rd),
    .clr_en_i   (wen_q),
    .clr_idx_i  (wt_index_q),
    .rs1_idx_i  (bus.rs1_index),
    .rs2_idx_i  (bus.rs2_index),
    .rs1_busy_o (sb_rs1_busy),
    .rs2_busy_o (sb_rs2_busy)
  );

  assign bus.wen      = wen_q;
  assign bus.wt_index = wt_index_q;
  assign bus.wdata    = wdata_q;

  assign rs1_hit = wen_q & (wt_index_q == bus.rs1_index) & idx_live(bus.rs1_index);
  assign rs2_hit = wen_q & (wt_index_q == bus.rs2_index) & idx_live(bus.rs2_index);

`ifdef GIR_WB_BYPASS_EN
  assign bus.rs1_fwd  = rs1_hit;
  assign bus.rs2_fwd  = rs2_hit;
  assign bus.fwd_data = wdata_q;
  assign bus.rs1_busy = idx_live(bus.rs1_index) & sb_rs1_busy & ~rs1_hit;
  assign bus.rs2_busy = idx_live(bus.rs2_index) & sb_rs2_busy & ~rs2_hit;
`else
  // Without forwarding the consumer stalls through the write cycle itself.
  assign bus.rs1_busy = idx_live(bus.rs1_index) & (sb_rs1_busy | rs1_hit);
  assign bus.rs2_busy = idx_live(bus.rs2_index) & (sb_rs2_busy | rs2_hit);
`endif

endmodule

// File: tb/tb_gir_wb_ctrl.sv
// Self-checking bench for gir_wb_ctrl; expected register-file writes are queued with the
// cycle they must appear in and checked every cycle on the falling edge.
module tb_gir_wb_ctrl;
  import gir_wb_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gir_wb_ctrl_if bus ();

  gir_wb_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned cyc;
    reg_idx_t    idx;
    xlen_t       data;
  } wb_exp_t;

  wb_exp_t     exp_q[$];
  int unsigned cyc    = 0;
  int          n_cmp  = 0;
  int          n_fail = 0;
`ifdef GIR_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  task automatic idle_inputs();
    bus.alu_valid     = 1'b0;
    bus.alu_rd        = '0;
    bus.alu_data      = '0;
    bus.ld_issue      = 1'b0;
    bus.ld_rd         = '0;
    bus.ld_resp_valid = 1'b0;
    bus.ld_resp_data  = '0;
    bus.rs1_index     = '0;
    bus.rs2_index     = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Record an accepted result; it must show up on the write port in the following cycle.
  task automatic expect_wb(input reg_idx_t idx, input xlen_t data);
    if (idx != '0) exp_q.push_back('{cyc + 1, idx, data});
  endtask

  // Falling-edge sample: the write port must match the head of the queue exactly when due.
  task automatic sample();
    logic exp_wen;
    @(negedge clk);
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wb_missing: idx %0d data %0h never written in cycle %0d",
               exp_q[0].idx, exp_q[0].data, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    exp_wen = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
    n_cmp++;
    if (bus.wen !== exp_wen) begin
      n_fail++;
      $display("FAIL wen cycle %0d: got %b want %b", cyc, bus.wen, exp_wen);
    end
    if (exp_wen) begin
      n_cmp++;
      if (bus.wt_index !== exp_q[0].idx) begin
        n_fail++;
        $display("FAIL wt_index cycle %0d: got %0d want %0d", cyc, bus.wt_index, exp_q[0].idx);
      end
      n_cmp++;
      if (bus.wdata !== exp_q[0].data) begin
        n_fail++;
        $display("FAIL wdata cycle %0d: got %0h want %0h", cyc, bus.wdata, exp_q[0].data);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    next();
    next();
    bus.rs1_index = 5'd1;
    bus.rs2_index = 5'd31;
    sample();
    n_cmp++;
    if (bus.wt_index !== '0 || bus.wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_wb: got idx %0d data %0h want 0 0", bus.wt_index, bus.wdata);
    end
    n_cmp++;
    if (bus.ld_issue_ready !== 1'b1 || bus.ld_resp_ready !== 1'b0 || bus.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got issue %b resp %b alu %b want 1 0 1",
               bus.ld_issue_ready, bus.ld_resp_ready, bus.alu_ready);
    end
    n_cmp++;
    if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b %b want 0 0", bus.rs1_busy, bus.rs2_busy);
    end
    rst = 1'b0;
    next();
    idle_inputs();
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 64'h1234;
    sample();
    n_cmp++;
    if (bus.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_ready: got %b want 1", bus.alu_ready);
    end
    expect_wb(5'd5, 64'h1234);
    next();
    bus.alu_valid = 1'b0;
    bus.rs1_index = 5'd5;
    sample();
    n_cmp++;
    if (bus.rs1_busy !== ~BYP) begin
      n_fail++;
      $display("FAIL alu_wen_busy: got %b want %b", bus.rs1_busy, ~BYP);
    end
    next();
    sample();
    n_cmp++;
    if (bus.rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_after_busy: got %b want 0", bus.rs1_busy);
    end
    next();
    idle_inputs();
  endtask

  task automatic test_load();
    bus.ld_issue  = 1'b1;
    bus.ld_rd     = 5'd7;
    bus.rs1_index = 5'd7;
    sample();
    n_cmp++;
    if (bus.ld_issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_issue_ready_idle: got %b want 1", bus.ld_issue_ready);
    end
    next();
    bus.ld_issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 64'hDEAD;
      end
      sample();
      n_cmp++;
      if (bus.ld_issue_ready !== 1'b0 || bus.ld_resp_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL ld_wait_ready step %0d: got issue %b resp %b want 0 1",
                 i, bus.ld_issue_ready, bus.ld_resp_ready);
      end
      n_cmp++;
      if (bus.rs1_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL ld_wait_busy step %0d: got %b want 1", i, bus.rs1_busy);
      end
      n_cmp++;
      if (bus.alu_ready !== (i != 2)) begin
        n_fail++;
        $display("FAIL ld_alu_ready step %0d: got %b want %b", i, bus.alu_ready, i != 2);
      end
      if (i == 2) expect_wb(5'd7, 64'hDEAD);
      next();
    end
    bus.ld_resp_valid = 1'b0;
    sample();
    n_cmp++;
    if (bus.ld_issue_ready !== 1'b1 || bus.rs1_busy !== ~BYP) begin
      n_fail++;
      $display("FAIL ld_wen_cycle: got issue %b busy %b want 1 %b",
               bus.ld_issue_ready, bus.rs1_busy, ~BYP);
    end
    next();
    sample();
    n_cmp++;
    if (bus.rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_after_busy: got %b want 0", bus.rs1_busy);
    end
    next();
    idle_inputs();
  endtask

  task automatic test_tie();
    bus.ld_issue = 1'b1;
    bus.ld_rd    = 5'd10;
    sample();
    next();
    bus.ld_issue      = 1'b0;
    bus.ld_resp_valid = 1'b1;
    bus.ld_resp_data  = 64'hBEEF;
    bus.alu_valid     = 1'b1;
    bus.alu_rd        = 5'd3;
    bus.alu_data      = 64'h33;
    sample();
    n_cmp++;
    if (bus.alu_ready !== 1'b0 || bus.ld_resp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_ready: got alu %b resp %b want 0 1", bus.alu_ready, bus.ld_resp_ready);
    end
    expect_wb(5'd10, 64'hBEEF);
    next();
    bus.ld_resp_valid = 1'b0;
    sample();
    n_cmp++;
    if (bus.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_alu_retry: got %b want 1", bus.alu_ready);
    end
    expect_wb(5'd3, 64'h33);
    next();
    bus.alu_valid = 1'b0;
    sample();
    next();
    sample();
    next();
    idle_inputs();
  endtask

  task automatic test_x0();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 64'hFF;
    sample();
    n_cmp++;
    if (bus.alu_ready !== 1'b1 || bus.rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_alu: got ready %b busy %b want 1 0", bus.alu_ready, bus.rs1_busy);
    end
    next();
    bus.alu_valid = 1'b0;
    bus.ld_issue  = 1'b1;
    bus.ld_rd     = 5'd0;
    sample();
    next();
    bus.ld_issue      = 1'b0;
    bus.ld_resp_valid = 1'b1;
    bus.ld_resp_data  = 64'h77;
    sample();
    n_cmp++;
    if (bus.ld_resp_ready !== 1'b1 || bus.rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_load: got resp %b busy %b want 1 0", bus.ld_resp_ready, bus.rs1_busy);
    end
    next();
    bus.ld_resp_valid = 1'b0;
    sample();
    n_cmp++;
    if (bus.ld_issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_load_done: got %b want 1", bus.ld_issue_ready);
    end
    next();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = reg_idx_t'(1 + i * 5);
      bus.alu_data  = {$urandom(), $urandom()};
      sample();
      n_cmp++;
      if (bus.alu_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready %0d: got %b want 1", i, bus.alu_ready);
      end
      expect_wb(bus.alu_rd, bus.alu_data);
      next();
    end
    idle_inputs();
    sample();
    next();
    sample();
    next();
  endtask

  task automatic test_rst_mid_load();
    bus.ld_issue = 1'b1;
    bus.ld_rd    = 5'd9;
    sample();
    next();
    bus.ld_issue  = 1'b0;
    bus.rs1_index = 5'd9;
    bus.rs2_index = 5'd9;
    sample();
    n_cmp++;
    if (bus.rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_busy: got %b want 1", bus.rs1_busy);
    end
    next();
    rst = 1'b1;
    sample();
    next();
    rst = 1'b0;
    bus.ld_resp_valid = 1'b1;
    bus.ld_resp_data  = 64'hBAD;
    sample();
    n_cmp++;
    if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || bus.ld_issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_load: got busy %b %b issue %b want 0 0 1",
               bus.rs1_busy, bus.rs2_busy, bus.ld_issue_ready);
    end
    n_cmp++;
    if (bus.ld_resp_ready !== 1'b0 || bus.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stale_resp: got resp %b alu %b want 0 1",
               bus.ld_resp_ready, bus.alu_ready);
    end
    next();
    idle_inputs();
    sample();
    next();
  endtask

`ifdef GIR_WB_BYPASS_EN
  task automatic test_bypass();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd4;
    bus.alu_data  = 64'h55;
    sample();
    expect_wb(5'd4, 64'h55);
    next();
    bus.alu_valid = 1'b0;
    bus.rs2_index = 5'd4;
    sample();
    n_cmp++;
    if (bus.rs2_fwd !== 1'b1 || bus.fwd_data !== 64'h55 || bus.rs2_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass: got fwd %b data %0h busy %b want 1 55 0",
               bus.rs2_fwd, bus.fwd_data, bus.rs2_busy);
    end
    next();
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_tie();
    test_x0();
    test_back_to_back();
    test_rst_mid_load();
`ifdef GIR_WB_BYPASS_EN
    test_bypass();
`endif
    sample();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wb_leftover: got %0d pending writes want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
